// File: rtl/fpu_sgn_pkg.sv
// fpu_sgn_pkg: rounding modes, operand classes and the classifier shared by the sign-resolve pipe
package fpu_sgn_pkg;

   localparam logic [1:0] RNE = 2'b00;
   localparam logic [1:0] RTZ = 2'b01;
   localparam logic [1:0] RUP = 2'b10;
   localparam logic [1:0] RDN = 2'b11;

   typedef struct packed {
      logic zero;
      logic inf;
      logic qnan;
      logic snan;
   } op_class_t;

   // Width-agnostic: the caller reduces the exponent and significand fields to these four flags
   function automatic op_class_t classify(
      input logic exp_ones,
      input logic exp_zero,
      input logic man_nz,
      input logic man_msb
   );
      op_class_t c;
      c.zero = exp_zero & ~man_nz;
      c.inf  = exp_ones & ~man_nz;
      c.qnan = exp_ones & man_nz & man_msb;
      c.snan = exp_ones & man_nz & ~man_msb;
      return c;
   endfunction

endpackage

// File: rtl/mag_compare.sv
// mag_compare: unsigned magnitude compare of two N-bit values
module mag_compare #(
   parameter int N = 31
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         gt,
   output logic         eq
);

   assign gt = a > b;
   assign eq = a == b;

endmodule

// File: rtl/sgn_resolve_pipe.sv
// sgn_resolve_pipe: two-stage FP add/sub sign, swap, effective-op and special-case resolver
module sgn_resolve_pipe
   import fpu_sgn_pkg::*;
#(
   parameter int EW = 8,
   parameter int SW = 23,
   localparam int W = EW + SW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] data_x_i,
   input  logic [W-1:0] data_y_i,
   input  logic         add_subt_i,
   input  logic [1:0]   rm_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         sgn_result_o,
   output logic         swap_o,
   output logic         eff_sub_o,
   output logic         zero_o,
   output logic         inf_o,
   output logic         nan_o,
   output logic         invalid_o
);

   logic      s1_valid, s2_valid, s1_adv, s2_adv;
   logic      s1_sx, s1_sy, s1_op, s1_gt, s1_eq;
   logic [1:0] s1_rm;
   op_class_t s1_cx, s1_cy;
   logic      gt, eq;
   op_class_t cx, cy;
   logic      r_eff, r_nan, r_inv, r_inf, r_sgn, r_swap, r_zero;

   assign s2_adv     = ~s2_valid | out_ready_i;
   assign s1_adv     = ~s1_valid | s2_adv;
   assign in_ready_o = s1_adv;
   assign out_valid_o = s2_valid;

   mag_compare #(.N(W-1)) u_cmp (
      .a  (data_x_i[W-2:0]),
      .b  (data_y_i[W-2:0]),
      .gt (gt),
      .eq (eq)
   );

   assign cx = classify(&data_x_i[W-2:SW], ~|data_x_i[W-2:SW], |data_x_i[SW-1:0], data_x_i[SW-1]);
   assign cy = classify(&data_y_i[W-2:SW], ~|data_y_i[W-2:SW], |data_y_i[SW-1:0], data_y_i[SW-1]);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sx    <= 1'b0;
         s1_sy    <= 1'b0;
         s1_op    <= 1'b0;
         s1_rm    <= 2'b00;
         s1_gt    <= 1'b0;
         s1_eq    <= 1'b0;
         s1_cx    <= '0;
         s1_cy    <= '0;
      end else begin
         s1_valid <= flush_i ? 1'b0 : s1_adv ? in_valid_i : s1_valid;
         if (s1_adv & in_valid_i & ~flush_i) begin
            s1_sx <= data_x_i[W-1];
            s1_sy <= data_y_i[W-1];
            s1_op <= add_subt_i;
            s1_rm <= rm_i;
            s1_gt <= gt;
            s1_eq <= eq;
            s1_cx <= cx;
            s1_cy <= cy;
         end
      end

   // Both-inf can never coexist with a NaN operand, so the invalid terms simply OR together
   always_comb begin
      r_eff  = s1_op ^ s1_sx ^ s1_sy;
      r_nan  = s1_cx.qnan | s1_cx.snan | s1_cy.qnan | s1_cy.snan | (s1_cx.inf & s1_cy.inf & r_eff);
      r_inv  = s1_cx.snan | s1_cy.snan | (s1_cx.inf & s1_cy.inf & r_eff);
      r_inf  = ~r_nan & (s1_cx.inf | s1_cy.inf);
      r_sgn  = r_nan ? 1'b0 :
               r_inf ? (s1_cx.inf ? s1_sx : s1_sy ^ s1_op) :
               s1_gt ? s1_sx :
               ~s1_eq ? s1_sy ^ s1_op :
               r_eff ? (s1_rm == RDN) : s1_sx;
      r_swap = ~r_nan & ~r_inf & ~s1_gt & ~s1_eq;
      r_zero = ~r_nan & ~r_inf & s1_eq & (r_eff | s1_cx.zero);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s2_valid     <= 1'b0;
         sgn_result_o <= 1'b0;
         swap_o       <= 1'b0;
         eff_sub_o    <= 1'b0;
         zero_o       <= 1'b0;
         inf_o        <= 1'b0;
         nan_o        <= 1'b0;
         invalid_o    <= 1'b0;
      end else begin
         s2_valid <= flush_i ? 1'b0 : s2_adv ? s1_valid : s2_valid;
         if (s2_adv & s1_valid & ~flush_i) begin
            sgn_result_o <= r_sgn;
            swap_o       <= r_swap;
            eff_sub_o    <= r_eff;
            zero_o       <= r_zero;
            inf_o        <= r_inf;
            nan_o        <= r_nan;
            invalid_o    <= r_inv;
         end
      end

endmodule

// File: tb/tb_sgn_resolve_pipe.sv
// tb_sgn_resolve_pipe: directed checks of sign resolution, specials, backpressure, reset and flush
module tb_sgn_resolve_pipe;

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, add_subt = 1'b0;
   logic [1:0]  rm = 2'b00;
   logic [31:0] x = '0, y = '0;
   logic        sgn, swap, eff, zero, inf, nan, inv;
   logic [6:0]  res;
   int          total = 0, bad = 0;

   assign res = {sgn, swap, eff, zero, inf, nan, inv};

   sgn_resolve_pipe #(.EW(8), .SW(23)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .data_x_i(x), .data_y_i(y), .add_subt_i(add_subt), .rm_i(rm),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .sgn_result_o(sgn), .swap_o(swap), .eff_sub_o(eff), .zero_o(zero),
      .inf_o(inf), .nan_o(nan), .invalid_o(inv)
   );

   always #5 clk = ~clk;

   // Expected result bits: {sgn, swap, eff_sub, zero, inf, nan, invalid}
   localparam int NV = 11;
   logic [31:0] vx  [NV] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h7F800000,
                             32'h7FC00000, 32'h7F800001, 32'hFF800000, 32'h3F800000, 32'h80000000, 32'h00000001};
   logic [31:0] vy  [NV] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 32'h7F800000,
                             32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h80000000, 32'h80000002};
   logic        vop [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0]  vrm [NV] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   logic [6:0]  vexp[NV] = '{7'b0000000, 7'b1110000, 7'b1011000, 7'b0011000, 7'b0010011,
                             7'b0000010, 7'b0000011, 7'b1010100, 7'b0000100, 7'b1001000, 7'b1110000};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int i);
      x = vx[i];
      y = vy[i];
      add_subt = vop[i];
      rm = vrm[i];
   endtask

   initial begin
      int sent, got;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      tick();
      for (int i = 0; i < NV; i++) begin
         drive(i);
         in_valid = 1'b1;
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_early", i), {31'd0, out_valid}, 32'd0);
         tick();
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_res", i), {25'd0, res}, {25'd0, vexp[i]});
      end
      tick();
      chk("idle_after_vecs", {31'd0, out_valid}, 32'd0);
      // Backpressure: out_ready low for the first three cycles
      sent = 0;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         out_ready = (c >= 3);
         in_valid = (sent < 4);
         drive(sent & 3);
         #1;
         if (c == 2) begin
            chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", {25'd0, res}, {25'd0, vexp[0]});
         end
         if (out_valid && out_ready) begin
            chk($sformatf("bp_out%0d", got), {25'd0, res}, {25'd0, vexp[got]});
            got++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", got, 32'd4);
      tick();
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
      // Asynchronous reset with work in flight
      drive(1);
      in_valid = 1'b1;
      tick();
      drive(2);
      tick();
      in_valid = 1'b0;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
      tick();
      #2 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("post_rst_quiet%0d", c), {31'd0, out_valid}, 32'd0);
      end
      // Flush with both stages full and a new operand offered
      drive(0);
      in_valid = 1'b1;
      tick();
      drive(1);
      tick();
      out_ready = 1'b0;
      drive(7);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("post_flush_quiet%0d", c), {31'd0, out_valid}, 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
